// File: rtl/ecc_test_sequencer_if.sv
// Handshake bundle between the ECC campaign sequencer and the channel path.
// master: the sequencer (drives CHAN_*/status, reads RUN and checker results).
// slave : the path/controller side (drives RUN and checker results).
//   RUN          campaign start request
//   CHECK_VALID  checker result strobe
//   CHECK_ERR    result mismatched (qualified by CHECK_VALID)
//   CHAN_RESET   reset to the generator/channel/checker path
//   CHAN_START   one-cycle start pulse to the generator
//   BUSY/DONE/PASS/TIMEOUT  campaign status and verdict
//   RUN_IDX      current run index
//   ERR_COUNT    accumulated bit errors
interface ecc_test_sequencer_if #(
  parameter int unsigned RUNS_NUMB = 4,
  parameter int unsigned BITS_NUMB = 10
);
  localparam int unsigned RW = (RUNS_NUMB > 1) ? $clog2(RUNS_NUMB) : 1;
  localparam int unsigned EW = $clog2(RUNS_NUMB * BITS_NUMB + 1);

  logic          RUN;
  logic          CHECK_VALID;
  logic          CHECK_ERR;
  logic          CHAN_RESET;
  logic          CHAN_START;
  logic          BUSY;
  logic          DONE;
  logic          PASS;
  logic          TIMEOUT;
  logic [RW-1:0] RUN_IDX;
  logic [EW-1:0] ERR_COUNT;

  modport master (
    input  RUN, CHECK_VALID, CHECK_ERR,
    output CHAN_RESET, CHAN_START, BUSY, DONE, PASS, TIMEOUT, RUN_IDX, ERR_COUNT
  );

  modport slave (
    output RUN, CHECK_VALID, CHECK_ERR,
    input  CHAN_RESET, CHAN_START, BUSY, DONE, PASS, TIMEOUT, RUN_IDX, ERR_COUNT
  );
endinterface

// File: rtl/ecc_test_sequencer.sv
// Campaign controller for the error-correction channel bench. Runs RUNS_NUMB
// back-to-back runs; each run resets the path, pulses CHAN_START and collects
// BITS_NUMB checker results, accumulating bit errors under a no-progress
// watchdog. Issues one PASS/FAIL verdict per campaign.
// Ports:
//   CLK    clock
//   RESET  synchronous, active-high reset
//   bus    ecc_test_sequencer_if.master (RUN/CHECK_* in, CHAN_*/status out)
module ecc_test_sequencer #(
  parameter int unsigned RUNS_NUMB      = 4,
  parameter int unsigned BITS_NUMB      = 10,
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_ERRORS     = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ecc_test_sequencer_if.master bus
);
  localparam int unsigned RW   = (RUNS_NUMB > 1) ? $clog2(RUNS_NUMB) : 1;
  localparam int unsigned EW   = $clog2(RUNS_NUMB * BITS_NUMB + 1);
  localparam int unsigned BW   = $clog2(BITS_NUMB + 1);
  localparam int unsigned CMAX = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_RESET_CHAN   = 3'd1;
  localparam logic [2:0] ST_START_RUN    = 3'd2;
  localparam logic [2:0] ST_WAIT_RESULTS = 3'd3;
  localparam logic [2:0] ST_RUN_END      = 3'd4;
  localparam logic [2:0] ST_FINISH       = 3'd5;

  logic [2:0]    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;       // reset-pulse length or watchdog
  logic [BW-1:0] bit_cnt_q,   bit_cnt_d;
  logic [RW-1:0] run_idx_q,   run_idx_d;
  logic [EW-1:0] err_count_q, err_count_d;
  logic          timeout_q,   timeout_d;
  logic          chan_reset_q, chan_reset_d;
  logic          chan_start_q, chan_start_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
  logic          pass_q,      pass_d;

  // Next state, counters, and outputs decoded from the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    run_idx_d   = run_idx_q;
    err_count_d = err_count_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (bus.RUN) begin
          err_count_d = '0;
          timeout_d   = 1'b0;
          run_idx_d   = '0;
          cnt_d       = '0;
          state_d     = ST_RESET_CHAN;
        end
      end
      ST_RESET_CHAN: begin
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          state_d = ST_START_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_START_RUN: begin
        bit_cnt_d = '0;
        cnt_d     = '0;
        state_d   = ST_WAIT_RESULTS;
      end
      ST_WAIT_RESULTS: begin
        // A result on the would-be expiry cycle reloads the watchdog instead
        if (bus.CHECK_VALID) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          cnt_d     = '0;
          if (bus.CHECK_ERR) begin
            err_count_d = err_count_q + EW'(1);
          end
          if (bit_cnt_q == BW'(BITS_NUMB - 1)) begin
            state_d = ST_RUN_END;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN_END: begin
        if (run_idx_q == RW'(RUNS_NUMB - 1)) begin
          state_d = ST_FINISH;
        end else begin
          run_idx_d = run_idx_q + RW'(1);
          cnt_d     = '0;
          state_d   = ST_RESET_CHAN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    chan_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESET_CHAN) || (state_d == ST_FINISH);
    chan_start_d = (state_d == ST_START_RUN);
    busy_d       = (state_d == ST_RESET_CHAN) || (state_d == ST_START_RUN) ||
                   (state_d == ST_WAIT_RESULTS) || (state_d == ST_RUN_END);
    done_d       = (state_d == ST_FINISH);
    pass_d       = done_d && !timeout_d && (32'(err_count_d) <= MAX_ERRORS);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      run_idx_q    <= '0;
      err_count_q  <= '0;
      timeout_q    <= 1'b0;
      chan_reset_q <= 1'b1;
      chan_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      run_idx_q    <= run_idx_d;
      err_count_q  <= err_count_d;
      timeout_q    <= timeout_d;
      chan_reset_q <= chan_reset_d;
      chan_start_q <= chan_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign bus.CHAN_RESET = chan_reset_q;
  assign bus.CHAN_START = chan_start_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.PASS       = pass_q;
  assign bus.TIMEOUT    = timeout_q;
  assign bus.RUN_IDX    = run_idx_q;
  assign bus.ERR_COUNT  = err_count_q;
endmodule
